// File: rtl/pc_pkg.sv
// Shared types for the program-counter block: condition codes, FSM states
// and the bit positions of the {Z,V,N} flag vector.
package pc_pkg;

  typedef enum logic [2:0] {
    COND_NEQ    = 3'b000,
    COND_EQ     = 3'b001,
    COND_GT     = 3'b010,
    COND_LT     = 3'b011,
    COND_GTE    = 3'b100,
    COND_LTE    = 3'b101,
    COND_OVFL   = 3'b110,
    COND_UNCOND = 3'b111
  } cond_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  localparam int Z_IDX = 2;
  localparam int V_IDX = 1;
  localparam int N_IDX = 0;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch-condition decoder; standalone so other pipeline
// stages can evaluate the same condition codes against their own flags.
module br_cond_eval
  import pc_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       cond_true
);

  logic z, v, n;

  always_comb begin
    z = flags[Z_IDX];
    v = flags[V_IDX];
    n = flags[N_IDX];
    cond_true = 1'b0;
    case (cond_e'(cond))
      COND_NEQ:    cond_true = !z;
      COND_EQ:     cond_true = z;
      COND_GT:     cond_true = !z && !n;
      COND_LT:     cond_true = n;
      COND_GTE:    cond_true = z || (!z && !n);
      COND_LTE:    cond_true = z || n;
      COND_OVFL:   cond_true = v;
      COND_UNCOND: cond_true = 1'b1;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with PC-relative / register branches and a RUN/HALT FSM.
// Define PC_UNIT_BR_STATS_EN to add saturating branch statistics counters.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               PC_W     = 16,
  parameter int               OFF_W    = 9,
  parameter logic [PC_W-1:0]  RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_is_reg,
  input  logic [2:0]       cond,
  input  logic [2:0]       flags,
  input  logic [OFF_W-1:0] offset,
  input  logic [PC_W-1:0]  rs_data,
  input  logic             halt_req,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_inc,
  output logic             br_taken,
  output logic             halted
`ifdef PC_UNIT_BR_STATS_EN
  ,
  output logic [31:0]      br_cnt,
  output logic [31:0]      br_taken_cnt
`endif
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;

  logic            cond_true;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] br_target;

  br_cond_eval u_cond (
    .cond      (cond),
    .flags     (flags),
    .cond_true (cond_true)
  );

  // Offset counts 16-bit words, so it is scaled to bytes before the add.
  always_comb begin
    pc_inc    = pc_q + PC_W'(2);
    off_ext   = PC_W'($signed(offset));
    br_target = br_is_reg ? rs_data : (pc_inc + (off_ext << 1));
    br_taken  = br_valid && cond_true && !stall && !halted_q && !halt_req;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    if (state_q == RUN && !stall) begin
      if (halt_req) begin
        state_d  = HALT;
        halted_d = 1'b1;
      end else if (br_taken) begin
        pc_d = br_target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign pc     = pc_q;
  assign halted = halted_q;

`ifdef PC_UNIT_BR_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] br_taken_cnt_q, br_taken_cnt_d;
  logic        br_seen;

  always_comb begin
    br_seen        = br_valid && !stall && !halt_req && (state_q == RUN);
    br_cnt_d       = br_cnt_q;
    br_taken_cnt_d = br_taken_cnt_q;
    if (br_seen && br_cnt_q != '1)
      br_cnt_d = br_cnt_q + 32'd1;
    if (br_taken && br_taken_cnt_q != '1)
      br_taken_cnt_d = br_taken_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q       <= '0;
      br_taken_cnt_q <= '0;
    end else begin
      br_cnt_q       <= br_cnt_d;
      br_taken_cnt_q <= br_taken_cnt_d;
    end
  end

  assign br_cnt       = br_cnt_q;
  assign br_taken_cnt = br_taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; the stats scenario runs only when
// PC_UNIT_BR_STATS_EN is defined for the build.
module tb_pc_unit;

  localparam int PC_W  = 16;
  localparam int OFF_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic             br_valid;
  logic             br_is_reg;
  logic [2:0]       cond;
  logic [2:0]       flags;
  logic [OFF_W-1:0] offset;
  logic [PC_W-1:0]  rs_data;
  logic             halt_req;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_inc;
  logic             br_taken;
  logic             halted;
`ifdef PC_UNIT_BR_STATS_EN
  logic [31:0]      br_cnt;
  logic [31:0]      br_taken_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [PC_W-1:0] exp_pc;

  // Hand-derived truth masks: bit f set when cond is true for flags={Z,V,N}=f.
  logic [7:0] cond_mask [8];

  pc_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_is_reg (br_is_reg),
    .cond      (cond),
    .flags     (flags),
    .offset    (offset),
    .rs_data   (rs_data),
    .halt_req  (halt_req),
    .pc        (pc),
    .pc_inc    (pc_inc),
    .br_taken  (br_taken),
    .halted    (halted)
`ifdef PC_UNIT_BR_STATS_EN
    ,
    .br_cnt       (br_cnt),
    .br_taken_cnt (br_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_valid = 0; br_is_reg = 0; cond = 3'b000;
    flags = 3'b000; offset = '0; rs_data = '0; halt_req = 0;
  endtask

  task automatic go_to(input logic [PC_W-1:0] addr);
    br_valid = 1; br_is_reg = 1; cond = 3'b111; rs_data = addr;
    step();
    idle_inputs();
    exp_pc = addr;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    exp_pc = 16'h0000;
    tests++;
    if (pc !== 16'h0000) begin fails++; $display("FAIL reset_pc got %h want %h", pc, 16'h0000); end
    tests++;
    if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", halted); end
    tests++;
    if (pc_inc !== 16'h0002) begin fails++; $display("FAIL reset_pc_inc got %h want 0002", pc_inc); end
  endtask

  task automatic test_idle();
    logic [PC_W-1:0] seq [4];
    seq[0] = 16'h0000; seq[1] = 16'h0002; seq[2] = 16'h0004; seq[3] = 16'h0006;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (pc !== seq[i] || halted !== 1'b0) begin
        fails++; $display("FAIL idle_seq[%0d] got pc=%h halted=%b want pc=%h halted=0", i, pc, halted, seq[i]);
      end
      if (i < 3) step();
    end
    exp_pc = 16'h0006;
  endtask

  task automatic test_rel_branch();
    go_to(16'h0010);
    br_valid = 1; br_is_reg = 0; cond = 3'b001; flags = 3'b100; offset = 9'h1FD;
    #1;
    tests++;
    if (br_taken !== 1'b1) begin fails++; $display("FAIL rel_taken got %b want 1", br_taken); end
    step();
    tests++;
    if (pc !== 16'h000C) begin fails++; $display("FAIL rel_target got %h want 000C", pc); end
    // Same branch with Z clear falls through to pc+2.
    flags = 3'b000;
    #1;
    tests++;
    if (br_taken !== 1'b0) begin fails++; $display("FAIL rel_not_taken got %b want 0", br_taken); end
    step();
    tests++;
    if (pc !== 16'h000E) begin fails++; $display("FAIL rel_fallthru got %h want 000E", pc); end
    // Forward offset +5 words from 0x000E: 0x0010 + 0x000A.
    flags = 3'b100; offset = 9'd5;
    step();
    tests++;
    if (pc !== 16'h001A) begin fails++; $display("FAIL rel_fwd got %h want 001A", pc); end
    idle_inputs();
    exp_pc = 16'h001A;
  endtask

  task automatic test_cond_sweep();
    logic exp_t;
    go_to(16'h0100);
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        br_valid = 1; br_is_reg = 1; rs_data = 16'h1234;
        cond = 3'(c); flags = 3'(f);
        exp_t = cond_mask[c][f];
        #1;
        tests++;
        if (br_taken !== exp_t) begin
          fails++; $display("FAIL sweep_taken c=%0d f=%0d got %b want %b", c, f, br_taken, exp_t);
        end
        exp_pc = exp_t ? 16'h1234 : exp_pc + 16'd2;
        step();
        tests++;
        if (pc !== exp_pc) begin
          fails++; $display("FAIL sweep_pc c=%0d f=%0d got %h want %h", c, f, pc, exp_pc);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap_stall();
    go_to(16'hFFFE);
    step();
    tests++;
    if (pc !== 16'h0000) begin fails++; $display("FAIL wrap got %h want 0000", pc); end
    stall = 1; br_valid = 1; br_is_reg = 1; cond = 3'b111; rs_data = 16'h5555; halt_req = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (br_taken !== 1'b0) begin fails++; $display("FAIL stall_taken[%0d] got %b want 0", i, br_taken); end
      if (i == 2) halt_req = 1;
      step();
      tests++;
      if (pc !== 16'h0000 || halted !== 1'b0) begin
        fails++; $display("FAIL stall_hold[%0d] got pc=%h halted=%b want 0000/0", i, pc, halted);
      end
    end
    idle_inputs();
    exp_pc = 16'h0000;
  endtask

  task automatic test_odd_reg();
    go_to(16'h0101);
    tests++;
    if (pc !== 16'h0101 || pc_inc !== 16'h0103) begin
      fails++; $display("FAIL odd_reg got pc=%h inc=%h want 0101/0103", pc, pc_inc);
    end
  endtask

  task automatic test_halt();
    go_to(16'h0020);
    halt_req = 1; br_valid = 1; br_is_reg = 1; cond = 3'b111; rs_data = 16'h4444;
    #1;
    tests++;
    if (br_taken !== 1'b0) begin fails++; $display("FAIL halt_vs_br got %b want 0", br_taken); end
    step();
    tests++;
    if (pc !== 16'h0020 || halted !== 1'b1) begin
      fails++; $display("FAIL halt_enter got pc=%h halted=%b want 0020/1", pc, halted);
    end
    halt_req = 0;
    #1;
    tests++;
    if (br_taken !== 1'b0) begin fails++; $display("FAIL halt_br_ignored got %b want 0", br_taken); end
    step();
    step();
    tests++;
    if (pc !== 16'h0020 || halted !== 1'b1) begin
      fails++; $display("FAIL halt_hold got pc=%h halted=%b want 0020/1", pc, halted);
    end
    stall = 1;
    rst = 1;
    step();
    rst = 0;
    idle_inputs();
    tests++;
    if (pc !== 16'h0000 || halted !== 1'b0) begin
      fails++; $display("FAIL halt_reset got pc=%h halted=%b want 0000/0", pc, halted);
    end
    step();
    tests++;
    if (pc !== 16'h0002) begin fails++; $display("FAIL halt_resume got %h want 0002", pc); end
  endtask

`ifdef PC_UNIT_BR_STATS_EN
  task automatic test_stats();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
    tests++;
    if (br_cnt !== 32'd0 || br_taken_cnt !== 32'd0) begin
      fails++; $display("FAIL stats_reset got %0d/%0d want 0/0", br_cnt, br_taken_cnt);
    end
    br_valid = 1; br_is_reg = 1; rs_data = 16'h0040;
    for (int i = 0; i < 6; i++) begin
      stall = (i == 2);
      cond  = (i == 1 || i == 4) ? 3'b001 : 3'b111;
      flags = 3'b000;
      step();
    end
    idle_inputs();
    tests++;
    if (br_cnt !== 32'd5 || br_taken_cnt !== 32'd3) begin
      fails++; $display("FAIL stats_counts got %0d/%0d want 5/3", br_cnt, br_taken_cnt);
    end
  endtask
`endif

  initial begin
    cond_mask[0] = 8'h0F; cond_mask[1] = 8'hF0; cond_mask[2] = 8'h05; cond_mask[3] = 8'hAA;
    cond_mask[4] = 8'hF5; cond_mask[5] = 8'hFA; cond_mask[6] = 8'hCC; cond_mask[7] = 8'hFF;
    rst = 1;
    idle_inputs();
    exp_pc = '0;
    test_reset();
    test_idle();
    test_rel_branch();
    test_cond_sweep();
    test_wrap_stall();
    test_odd_reg();
    test_halt();
`ifdef PC_UNIT_BR_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter PC_W, default 16, width of PC and of every address port.
REQ-002 Parameter OFF_W, default 9, width of the signed word-offset field for PC-relative branches.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 stall  in  1  hold the PC; ignore branch and halt this cycle.
REQ-008 br_valid  in  1  the current instruction is a branch.
REQ-009 br_is_reg  in  1  1: target = rs_data; 0: target = PC-relative.
REQ-010 cond  in  3  condition code: 000 NEQ, 001 EQ, 010 GT, 011 LT, 100 GTE, 101 LTE, 110 OVFL, 111 UNCOND.
REQ-011 flags  in  3  {Z,V,N}: flags[2]=Z, flags[1]=V, flags[0]=N.
REQ-012 offset  in  OFF_W  signed word offset.
REQ-013 rs_data  in  PC_W  register branch target.
REQ-014 halt_req  in  1  the current instruction is HLT.
REQ-015 pc  out  PC_W  registered current PC.
REQ-016 pc_inc  out  PC_W  combinational pc+2.
REQ-017 br_taken  out  1  combinational; the branch resolves taken this cycle.
REQ-018 halted  out  1  registered; the block is in HALT.

Function
REQ-019 The condition decode SHALL be as follows: NEQ !Z; EQ Z; GT !Z&!N; LT N; GTE Z|(!Z&!N); LTE Z|N; OVFL V; UNCOND 1.
REQ-020 br_taken SHALL equal br_valid & cond_true & !stall & !halted & !halt_req.
REQ-021 The relative target SHALL be pc_inc + (sign-extend(offset) << 1), computed modulo 2^PC_W.
REQ-022 All PC arithmetic SHALL wrap silently; there is no overflow output.
REQ-023 The FSM SHALL have two states, RUN and HALT; reset enters RUN.
REQ-024 In RUN with stall=1, pc SHALL hold and the state SHALL be unchanged.
REQ-025 In RUN with stall=0 and halt_req=1, pc SHALL hold (it stays on the HLT address), the state SHALL become HALT, and halted SHALL assert the next cycle.
REQ-026 In RUN with stall=0, halt_req=0 and br_taken=1, pc SHALL load the target on the next edge.
REQ-027 In RUN otherwise, pc SHALL load pc_inc on the next edge.
REQ-028 In HALT, pc SHALL hold and every input except rst SHALL be ignored; only reset exits HALT.
REQ-029 When halt_req and br_valid are both asserted, halt SHALL win and the branch SHALL be discarded.
REQ-030 A register branch with an odd rs_data SHALL load rs_data unchanged; no alignment correction is applied.
REQ-031 The pc update latency SHALL be exactly one cycle, with no bubbles inserted.

Reset
REQ-032 On rst=1 at a clock edge, pc SHALL become RESET_PC, the state SHALL become RUN, halted SHALL become 0, and stats counters SHALL become 0.
REQ-033 Reset SHALL take priority over stall, halt and branch, including while in HALT.

Configuration
REQ-034 Macro PC_UNIT_BR_STATS_EN: when defined, add outputs br_cnt and br_taken_cnt (32 bits each).
REQ-035 br_cnt SHALL count cycles where br_valid & !stall & !halt_req & RUN; br_taken_cnt SHALL count br_taken cycles; both saturate at all-ones.
REQ-036 When PC_UNIT_BR_STATS_EN is undefined, the ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-037 Package pc_pkg SHALL hold the cond_e enum (8 codes), the state_e enum (RUN, HALT) and the flag bit-index constants Z_IDX=2, V_IDX=1, N_IDX=0.
REQ-038 Sub-module br_cond_eval SHALL be combinational, with cond and flags in and cond_true out; it is reusable by other pipeline stages.

Verification
REQ-039 Reset, then 4 cycles idle -> pc sequence 0, 2, 4, 6; halted=0.
REQ-040 pc=0x0010, br_valid=1, br_is_reg=0, cond=001, Z=1, offset=-3 -> br_taken=1, next pc=0x000C.
REQ-041 Sweep all 8 cond values x all 8 flag values with br_is_reg=1, rs_data=0x1234 -> taken matches REQ-019; next pc is 0x1234 or pc+2 accordingly.
REQ-042 pc=0xFFFE, no branch -> next pc=0x0000 (wrap); stall=1 for 3 cycles -> pc holds 0x0000.
REQ-043 halt_req=1 with br_valid=1 and cond=111 at pc=0x0020 -> pc stays 0x0020, halted=1 next cycle, a later branch is ignored, then rst -> pc=RESET_PC and halted=0.
REQ-044 With PC_UNIT_BR_STATS_EN: 5 branches, 3 taken, 1 stalled branch -> br_cnt=5, br_taken_cnt=3.
